npu_result_argmax: RTL and testbench

//  Downstream consumer of the NPU scratch RAM result line. After inference it scans
//  NUM_ENTRIES result bytes through the RAM's byte-select read port and reports the

---
 rtl/npu_result_argmax.sv | 184 ++++++++++++++++++
 tb/tb_npu_result_argmax.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_result_argmax.sv
// Scans NUM_ENTRIES result bytes through a 2-cycle-latency RAM read port and reports argmax/max.
// Optional define NPU_ARGMAX_TOP2_EN adds second_o (index of the second-largest score).
module npu_result_argmax #(
    parameter int NUM_ENTRIES = 10,
    parameter int BASE_ADDR   = 0,
    parameter bit SIGNED_CMP  = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       ram_wr_i,
    input  logic [7:0] rslt_data_i,
    output logic [7:0] rslt_addr_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [7:0] class_o,
    output logic [7:0] max_o
`ifdef NPU_ARGMAX_TOP2_EN
    ,
    output logic [7:0] second_o
`endif
);

    localparam logic [7:0] FIRST_ADDR = 8'(BASE_ADDR);
    localparam logic [7:0] LAST_IDX   = 8'(NUM_ENTRIES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t     state;
    state_t     state_next;
    logic       accept;
    logic       abort;
    logic [7:0] idx;
    logic       drain_last;
    logic       vld0;
    logic       vld1;
    logic [7:0] idx1;
    logic       have_best;
    logic [7:0] best_val;
    logic [7:0] best_idx;
`ifdef NPU_ARGMAX_TOP2_EN
    logic       have_sec;
    logic [7:0] sec_val;
    logic [7:0] sec_idx;
`endif

    function automatic logic greater(input logic [7:0] a, input logic [7:0] b);
        if (SIGNED_CMP)
            return $signed(a) > $signed(b);
        else
            return a > b;
    endfunction

    assign accept = (state == IDLE) && start_i && !ram_wr_i;
    assign abort  = ram_wr_i && ((state == SCAN) || (state == DRAIN));

    // NOTE: reset is synchronous; rst_i is only looked at on the rising clock edge.
    always_ff @(posedge clk_i) begin
        if (!rst_i)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SCAN;
            SCAN: begin
                if (abort)
                    state_next = DONE;
                else if (idx == LAST_IDX)
                    state_next = DRAIN;
            end
            DRAIN:   if (abort || drain_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state != IDLE);
        done_o = (state == DONE);
    end

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rslt_addr_o <= '0;
            err_o       <= 1'b0;
            class_o     <= '0;
            max_o       <= '0;
            idx         <= '0;
            drain_last  <= 1'b0;
            vld0        <= 1'b0;
            vld1        <= 1'b0;
            idx1        <= '0;
            have_best   <= 1'b0;
            best_val    <= '0;
            best_idx    <= '0;
`ifdef NPU_ARGMAX_TOP2_EN
            second_o    <= '0;
            have_sec    <= 1'b0;
            sec_val     <= '0;
            sec_idx     <= '0;
`endif
        end else begin
            // Tag pipe: vld0 marks an address on the bus, vld1 marks its data arriving.
            vld0 <= (state_next == SCAN);
            vld1 <= vld0 && !abort;
            idx1 <= idx;

            case (state)
                IDLE: begin
                    if (accept) begin
                        rslt_addr_o <= FIRST_ADDR;
                        idx         <= '0;
                        err_o       <= 1'b0;
                        drain_last  <= 1'b0;
                    end
                end
                SCAN: begin
                    if (abort) begin
                        err_o <= 1'b1;
                    end else if (idx != LAST_IDX) begin
                        rslt_addr_o <= rslt_addr_o + 8'd1;
                        idx         <= idx + 8'd1;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        err_o <= 1'b1;
                    end else if (drain_last) begin
                        class_o  <= best_idx;
                        max_o    <= best_val;
`ifdef NPU_ARGMAX_TOP2_EN
                        second_o <= sec_idx;
`endif
                    end else begin
                        drain_last <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (accept) begin
                have_best <= 1'b0;
                best_val  <= '0;
                best_idx  <= '0;
`ifdef NPU_ARGMAX_TOP2_EN
                have_sec  <= 1'b0;
                sec_val   <= '0;
                sec_idx   <= '0;
`endif
            end else if (vld1) begin
                // Strict compares keep the earliest index on ties.
                if (!have_best) begin
                    have_best <= 1'b1;
                    best_val  <= rslt_data_i;
                    best_idx  <= idx1;
`ifdef NPU_ARGMAX_TOP2_EN
                    sec_val   <= rslt_data_i;
                    sec_idx   <= idx1;
`endif
                end else if (greater(rslt_data_i, best_val)) begin
                    best_val <= rslt_data_i;
                    best_idx <= idx1;
`ifdef NPU_ARGMAX_TOP2_EN
                    have_sec <= 1'b1;
                    sec_val  <= best_val;
                    sec_idx  <= best_idx;
                end else if (!have_sec || greater(rslt_data_i, sec_val)) begin
                    have_sec <= 1'b1;
                    sec_val  <= rslt_data_i;
                    sec_idx  <= idx1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_npu_result_argmax.sv
// Self-checking bench: four argmax instances with different geometry/signedness share one RAM image.
// Define NPU_ARGMAX_TOP2_EN to also check second_o.
module tb_npu_result_argmax;

    localparam int N0 = 10, B0 = 0;
    localparam int N1 = 10, B1 = 0;
    localparam int N2 = 1,  B2 = 3;
    localparam int N3 = 16, B3 = 64;
    localparam bit S0 = 1'b1, S1 = 1'b0, S2 = 1'b1, S3 = 1'b0;

    function automatic int n_of(input int k);
        case (k)
            0: return N0;
            1: return N1;
            2: return N2;
            default: return N3;
        endcase
    endfunction

    function automatic int base_of(input int k);
        case (k)
            0: return B0;
            1: return B1;
            2: return B2;
            default: return B3;
        endcase
    endfunction

    function automatic int sgn_of(input int k);
        case (k)
            0: return int'(S0);
            1: return int'(S1);
            2: return int'(S2);
            default: return int'(S3);
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_i;
    logic            start_i;
    logic            ram_wr_i;
    logic [3:0][7:0] rdata;
    logic [3:0][7:0] addr;
    logic [3:0][7:0] cls;
    logic [3:0][7:0] mx;
    logic [3:0]      busy;
    logic [3:0]      done;
    logic [3:0]      err;
`ifdef NPU_ARGMAX_TOP2_EN
    logic [3:0][7:0] sec;
`endif
    logic [7:0]      mem [0:255];

    // Read port: address seen at edge k+1 is returned, sampled by the DUT at edge k+2.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) rdata[k] <= mem[addr[k]];
    end

    npu_result_argmax #(.NUM_ENTRIES(N0), .BASE_ADDR(B0), .SIGNED_CMP(S0)) u_dut0 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .ram_wr_i(ram_wr_i),
        .rslt_data_i(rdata[0]), .rslt_addr_o(addr[0]), .busy_o(busy[0]), .done_o(done[0]),
        .err_o(err[0]), .class_o(cls[0]), .max_o(mx[0])
`ifdef NPU_ARGMAX_TOP2_EN
        , .second_o(sec[0])
`endif
    );

    npu_result_argmax #(.NUM_ENTRIES(N1), .BASE_ADDR(B1), .SIGNED_CMP(S1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .ram_wr_i(ram_wr_i),
        .rslt_data_i(rdata[1]), .rslt_addr_o(addr[1]), .busy_o(busy[1]), .done_o(done[1]),
        .err_o(err[1]), .class_o(cls[1]), .max_o(mx[1])
`ifdef NPU_ARGMAX_TOP2_EN
        , .second_o(sec[1])
`endif
    );

    npu_result_argmax #(.NUM_ENTRIES(N2), .BASE_ADDR(B2), .SIGNED_CMP(S2)) u_dut2 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .ram_wr_i(ram_wr_i),
        .rslt_data_i(rdata[2]), .rslt_addr_o(addr[2]), .busy_o(busy[2]), .done_o(done[2]),
        .err_o(err[2]), .class_o(cls[2]), .max_o(mx[2])
`ifdef NPU_ARGMAX_TOP2_EN
        , .second_o(sec[2])
`endif
    );

    npu_result_argmax #(.NUM_ENTRIES(N3), .BASE_ADDR(B3), .SIGNED_CMP(S3)) u_dut3 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .ram_wr_i(ram_wr_i),
        .rslt_data_i(rdata[3]), .rslt_addr_o(addr[3]), .busy_o(busy[3]), .done_o(done[3]),
        .err_o(err[3]), .class_o(cls[3]), .max_o(mx[3])
`ifdef NPU_ARGMAX_TOP2_EN
        , .second_o(sec[3])
`endif
    );

    int checks = 0;
    int errors = 0;
    int exp_cls [4];
    int exp_max [4];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Score as a plain integer under the chosen signedness.
    function automatic int score(input logic [7:0] b, input int sgn);
        int v;
        v = int'(b);
        if (sgn != 0 && v >= 128) v = v - 256;
        return v;
    endfunction

    // Reference: first index of the maximum; second = first index of the max among the rest.
    function automatic void ref_scan(input int base, input int n, input int sgn,
                                     output int c, output int m, output int s);
        int best;
        int sb;
        int v;
        bit found;
        c = 0;
        best = 0;
        for (int i = 0; i < n; i++) begin
            v = score(mem[base + i], sgn);
            if (i == 0 || v > best) begin
                best = v;
                c = i;
            end
        end
        m = int'(mem[base + c]);
        s = c;
        sb = 0;
        found = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i != c) begin
                v = score(mem[base + i], sgn);
                if (!found || v > sb) begin
                    sb = v;
                    s = i;
                    found = 1'b1;
                end
            end
        end
    endfunction

    function automatic int all_outputs(input int k);
        int v;
        v = int'({addr[k], cls[k], mx[k], busy[k], done[k], err[k]});
`ifdef NPU_ARGMAX_TOP2_EN
        v = v | int'(sec[k]);
`endif
        return v;
    endfunction

    // One clean scan on every instance: done timing, pulse width, and dut0 busy/addr/err profile.
    task automatic run_scan();
        int done_edge [4];
        int done_cnt [4];
        int prof_err;
        for (int k = 0; k < 4; k++) begin
            done_edge[k] = -1;
            done_cnt[k] = 0;
        end
        prof_err = 0;
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        for (int e = 0; e <= 22; e++) begin
            if (e > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            for (int k = 0; k < 4; k++) begin
                if (done[k]) begin
                    if (done_edge[k] < 0) done_edge[k] = e;
                    done_cnt[k]++;
                end
            end
            if (busy[0] !== (e <= N0 + 2)) prof_err++;
            if (addr[0] !== 8'(B0 + ((e < N0) ? e : N0 - 1))) prof_err++;
            if (err[0] !== 1'b0) prof_err++;
        end
        check("dut0 busy/addr/err profile", prof_err, 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("dut%0d done edge", k), done_edge[k], n_of(k) + 2);
            check($sformatf("dut%0d done width", k), done_cnt[k], 1);
        end
    endtask

    task automatic check_results(input string tag);
        int c, m, s;
        for (int k = 0; k < 4; k++) begin
            ref_scan(base_of(k), n_of(k), sgn_of(k), c, m, s);
            check($sformatf("%s dut%0d class", tag, k), int'(cls[k]), c);
            check($sformatf("%s dut%0d max", tag, k), int'(mx[k]), m);
            check($sformatf("%s dut%0d err", tag, k), int'(err[k]), 0);
`ifdef NPU_ARGMAX_TOP2_EN
            check($sformatf("%s dut%0d second", tag, k), int'(sec[k]), s);
`endif
            exp_cls[k] = c;
            exp_max[k] = m;
        end
    endtask

    // Write strobe sampled at scan edge 'at' aborts every instance still scanning or draining.
    task automatic abort_at(input int at);
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        for (int e = 1; e < at; e++) begin
            @(posedge clk);
            @(negedge clk);
        end
        ram_wr_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ram_wr_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k != 2) begin
                check($sformatf("abort@%0d dut%0d done", at, k), int'(done[k]), 1);
                check($sformatf("abort@%0d dut%0d err", at, k), int'(err[k]), 1);
                check($sformatf("abort@%0d dut%0d class kept", at, k), int'(cls[k]), exp_cls[k]);
                check($sformatf("abort@%0d dut%0d max kept", at, k), int'(mx[k]), exp_max[k]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check($sformatf("abort@%0d dut0 busy after", at), int'(busy[0]), 0);
        check($sformatf("abort@%0d dut0 err sticky", at), int'(err[0]), 1);
        repeat (4) @(posedge clk);
    endtask

    typedef struct packed {
        logic [9:0][7:0] s;     // s[i] is entry i
        logic [7:0]      cls_s;
        logic [7:0]      max_s;
        logic [7:0]      cls_u;
        logic [7:0]      max_u;
        logic [7:0]      sec_s;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int watch;

        // Entries listed from index 9 down to index 0.
        tbl[0] = '{s: {8'd5, 8'd127, 8'h80, 8'd1, 8'd0, 8'd9, 8'd7, 8'hFE, 8'd9, 8'd3},
                   cls_s: 8'd8, max_s: 8'h7F, cls_u: 8'd2, max_u: 8'hFE, sec_s: 8'd1};
        tbl[1] = '{s: {10{8'h11}},
                   cls_s: 8'd0, max_s: 8'h11, cls_u: 8'd0, max_u: 8'h11, sec_s: 8'd1};
        tbl[2] = '{s: {10{8'h80}},
                   cls_s: 8'd0, max_s: 8'h80, cls_u: 8'd0, max_u: 8'h80, sec_s: 8'd1};
        tbl[3] = '{s: {8'hFF, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0},
                   cls_s: 8'd8, max_s: 8'd8, cls_u: 8'd9, max_u: 8'hFF, sec_s: 8'd7};
        tbl[4] = '{s: {8'hFA, 8'hFC, 8'hFF, 8'hF7, 8'hFE, 8'hF9, 8'hFD, 8'hFF, 8'hFB, 8'hFF},
                   cls_s: 8'd0, max_s: 8'hFF, cls_u: 8'd0, max_u: 8'hFF, sec_s: 8'd2};

        rst_i = 1'b0;
        start_i = 1'b0;
        ram_wr_i = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) check($sformatf("reset dut%0d outputs", k), all_outputs(k), 0);
        rst_i = 1'b1;

        // Start with the RAM write strobe high is not accepted.
        @(negedge clk);
        start_i = 1'b1;
        ram_wr_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        ram_wr_i = 1'b0;
        check("start during ram write ignored", int'(busy[0]), 0);

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 80; i++) mem[i] = 8'($urandom);
            for (int i = 0; i < 10; i++) mem[i] = tbl[t].s[i];
            run_scan();
            check($sformatf("T%0d signed class", t), int'(cls[0]), int'(tbl[t].cls_s));
            check($sformatf("T%0d signed max", t), int'(mx[0]), int'(tbl[t].max_s));
            check($sformatf("T%0d unsigned class", t), int'(cls[1]), int'(tbl[t].cls_u));
            check($sformatf("T%0d unsigned max", t), int'(mx[1]), int'(tbl[t].max_u));
`ifdef NPU_ARGMAX_TOP2_EN
            check($sformatf("T%0d signed second", t), int'(sec[0]), int'(tbl[t].sec_s));
`endif
            check_results($sformatf("T%0d", t));
        end

        abort_at(4);
        abort_at(12);
        run_scan();
        check_results("post-abort clean");

        // Start while busy is ignored; reset mid-scan clears everything and suppresses done.
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        check("start while busy ignored (addr)", int'(addr[0]), B0 + 2);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) check($sformatf("mid-scan reset dut%0d", k), all_outputs(k), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        watch = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done != 4'b0000) watch++;
        end
        check("no done after mid-scan reset", watch, 0);

        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < 80; i++) begin
                if (it % 3 == 0) begin
                    case ($urandom_range(0, 3))
                        0: mem[i] = 8'h7F;
                        1: mem[i] = 8'h80;
                        2: mem[i] = 8'hFF;
                        default: mem[i] = 8'h00;
                    endcase
                end else begin
                    mem[i] = 8'($urandom);
                end
            end
            run_scan();
            check_results($sformatf("rand%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
